// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, memory and completion signals of the two-port memory arbiter
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_address;
  logic [31:0] i_data_read;
  logic        i_data_valid;
  logic        i_err;
  logic        d_req;
  logic        d_write_enable;
  logic [31:0] d_address;
  logic [31:0] d_data_write;
  logic [31:0] d_data_read;
  logic        d_data_valid;
  logic        d_err;
  logic        m_req;
  logic        m_write_enable;
  logic [31:0] m_address;
  logic [31:0] m_data_write;
  logic [31:0] m_data_read;
  logic        m_data_valid;
  modport slave (
    input  i_req, i_address, d_req, d_write_enable, d_address, d_data_write, m_data_read, m_data_valid,
    output i_data_read, i_data_valid, i_err, d_data_read, d_data_valid, d_err,
           m_req, m_write_enable, m_address, m_data_write
  );
  modport master (
    output i_req, i_address, d_req, d_write_enable, d_address, d_data_write, m_data_read, m_data_valid,
    input  i_data_read, i_data_valid, i_err, d_data_read, d_data_valid, d_err,
           m_req, m_write_enable, m_address, m_data_write
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between fetch and data ports, with timeout
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  state_t      r_state, w_next;
  logic        r_last_d;
  logic [15:0] r_cnt;
  logic        r_m_req, r_m_we;
  logic [31:0] r_m_addr, r_m_wdata;
  logic        w_grant_d, w_start, w_sel_d, w_fin, w_err, w_iv, w_dv;
  logic [31:0] w_data;
  // arbitration, completion decode and response routing; reset suppresses any completion pulse
  always_comb begin
    w_grant_d = bus.d_req && !(bus.i_req && r_last_d);
    w_fin = !reset && r_state != IDLE && (bus.m_data_valid || (TIMEOUT != 0 && r_cnt == TO_LAST));
    w_err = w_fin && !bus.m_data_valid;
    w_data = w_err ? '0 : bus.m_data_read;
    w_next = r_state == IDLE ? (w_grant_d ? D_BUSY : bus.i_req ? I_BUSY : IDLE) : w_fin ? IDLE : r_state;
    w_start = r_state == IDLE && w_next != IDLE;
    w_sel_d = w_next == D_BUSY;
    w_iv = w_fin && r_state == I_BUSY;
    w_dv = w_fin && r_state == D_BUSY;
  end
  // state, round-robin pointer, busy-cycle counter and latched memory request
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_last_d  <= 1'b0;
      r_cnt     <= '0;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= r_state == IDLE ? '0 : r_cnt + 16'd1;
      r_m_req <= w_next != IDLE;
      if (w_start) begin
        r_last_d  <= w_sel_d;
        r_m_addr  <= w_sel_d ? bus.d_address : bus.i_address;
        r_m_we    <= w_sel_d && bus.d_write_enable;
        r_m_wdata <= w_sel_d ? bus.d_data_write : '0;
      end
    end
  end
  assign bus.m_req          = r_m_req;
  assign bus.m_write_enable = r_m_we;
  assign bus.m_address      = r_m_addr;
  assign bus.m_data_write   = r_m_wdata;
  assign bus.i_data_valid   = w_iv;
  assign bus.i_err          = w_iv && w_err;
  assign bus.i_data_read    = w_iv ? w_data : '0;
  assign bus.d_data_valid   = w_dv;
  assign bus.d_err          = w_dv && w_err;
  assign bus.d_data_read    = w_dv ? w_data : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural memory
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mem_arbiter_if bus();
  mem_arbiter_if bus0();
  mem_arbiter #(.TIMEOUT(4)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  mem_arbiter #(.TIMEOUT(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  typedef struct {
    bit          d;
    logic [31:0] data;
    bit          err;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int mem_lat = 0;
  bit mem_over = 0;
  logic [31:0] mem_val = '0;
  bit gap_chk = 0;
  bit gap_seen = 0;
  bit done0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory model: answers mem_lat cycles after m_req rises (0 = never); reads return addr ^ CAFE0000
  initial begin
    int mcnt;
    int lows;
    mcnt = 0;
    lows = 0;
    bus.m_data_valid = 1'b0;
    bus.m_data_read = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.m_data_valid = 1'b0;
      bus.m_data_read = '0;
      if (!bus.m_req) begin
        mcnt = 0;
        lows++;
      end else begin
        if (mcnt == 0) begin
          if (gap_chk && gap_seen) chk("gap_cycles", lows, 1);
          gap_seen = 1;
          lows = 0;
        end
        mcnt++;
        if (mem_lat > 0 && mcnt == mem_lat) begin
          bus.m_data_valid = 1'b1;
          bus.m_data_read = mem_over ? mem_val : bus.m_write_enable ? 32'h0 : bus.m_address ^ 32'hCAFE_0000;
        end
      end
    end
  end

  // monitor: pops the scoreboard on every completion pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.i_data_valid && bus.d_data_valid)
        chk("valid_onehot", 32'(bus.i_data_valid & bus.d_data_valid), 0);
      else if (bus.i_data_valid || bus.d_data_valid) begin
        if (q.size() == 0)
          chk("unexpected_valid", {30'b0, bus.d_data_valid, bus.i_data_valid}, 0);
        else begin
          e = q.pop_front();
          chk("port_d", 32'(bus.d_data_valid), 32'(e.d));
          chk("data", e.d ? bus.d_data_read : bus.i_data_read, e.data);
          chk("err", 32'(e.d ? bus.d_err : bus.i_err), 32'(e.err));
          chk("m_address", bus.m_address, e.addr);
          chk("m_we", 32'(bus.m_write_enable), 32'(e.we));
          if (e.we) chk("m_wdata", bus.m_data_write, e.wdata);
        end
      end
      if (!bus.i_data_valid) chk("i_idle_out", bus.i_data_read | {31'b0, bus.i_err}, 0);
      if (!bus.d_data_valid) chk("d_idle_out", bus.d_data_read | {31'b0, bus.d_err}, 0);
    end
  end

  task automatic reset_vals();
    chk("rst_m_req", 32'(bus.m_req), 0);
    chk("rst_m_we", 32'(bus.m_write_enable), 0);
    chk("rst_m_address", bus.m_address, 0);
    chk("rst_m_wdata", bus.m_data_write, 0);
    chk("rst_valids", {30'b0, bus.d_data_valid, bus.i_data_valid}, 0);
    chk("rst_errs", {30'b0, bus.d_err, bus.i_err}, 0);
    chk("rst_i_data", bus.i_data_read, 0);
    chk("rst_d_data", bus.d_data_read, 0);
  endtask

  task automatic txn(input bit d, input logic [31:0] addr, input bit we, input logic [31:0] wdata,
                     input int lat, input bit over, input logic [31:0] val,
                     input logic [31:0] exp_data, input bit exp_err, input int exp_cyc);
    int cyc;
    bit got;
    mem_lat = lat;
    mem_over = over;
    mem_val = val;
    q.push_back('{d, exp_data, exp_err, addr, we, wdata});
    if (d) begin
      bus.d_req = 1'b1;
      bus.d_write_enable = we;
      bus.d_address = addr;
      bus.d_data_write = wdata;
    end else begin
      bus.i_req = 1'b1;
      bus.i_address = addr;
    end
    cyc = 0;
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(posedge clk);
      #2;
      if (bus.m_req) cyc++;
      got = d ? bus.d_data_valid : bus.i_data_valid;
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    chk("txn_done", 32'(got), 1);
    chk("txn_latency", cyc, exp_cyc);
    @(posedge clk);
    #2;
    chk("m_req_drop", 32'(bus.m_req), 0);
  endtask

  task automatic contend(input int n);
    int done;
    mem_lat = 2;
    mem_over = 0;
    gap_seen = 0;
    gap_chk = 1;
    for (int j = 0; j < n; j++)
      if (j % 2 == 0) q.push_back('{1'b1, 32'hCAFE_0300, 1'b0, 32'h300, 1'b0, 32'h0});
      else q.push_back('{1'b0, 32'hCAFE_0200, 1'b0, 32'h200, 1'b0, 32'h0});
    bus.d_write_enable = 1'b0;
    bus.d_address = 32'h300;
    bus.i_address = 32'h200;
    bus.d_req = 1'b1;
    bus.i_req = 1'b1;
    done = 0;
    for (int k = 0; k < 20 * n && done < n; k++) begin
      @(posedge clk);
      #2;
      if (bus.i_data_valid || bus.d_data_valid) done++;
    end
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
    gap_chk = 0;
    chk("contend_done", done, n);
    @(posedge clk);
    #2;
  endtask

  // TIMEOUT = 0 instance: memory never answers, so no completion may ever appear
  initial begin
    int n0;
    bus0.i_req = 1'b0;
    bus0.i_address = '0;
    bus0.d_req = 1'b0;
    bus0.d_write_enable = 1'b0;
    bus0.d_address = '0;
    bus0.d_data_write = '0;
    bus0.m_data_read = '0;
    bus0.m_data_valid = 1'b0;
    @(negedge reset);
    bus0.i_req = 1'b1;
    bus0.i_address = 32'h80;
    n0 = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus0.i_data_valid || bus0.d_data_valid) n0++;
    end
    chk("t0_no_completion", n0, 0);
    chk("t0_m_req_held", 32'(bus0.m_req), 1);
    done0 = 1;
  end

  initial begin
    bus.i_req = 1'b0;
    bus.i_address = '0;
    bus.d_req = 1'b0;
    bus.d_write_enable = 1'b0;
    bus.d_address = '0;
    bus.d_data_write = '0;
    repeat (2) @(posedge clk);
    #2;
    reset_vals();
    reset = 1'b0;
    txn(0, 32'h100, 0, 32'h0, 2, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 2);
    txn(1, 32'h40, 1, 32'h1234_5678, 2, 0, 32'h0, 32'h0, 0, 2);
    txn(0, 32'h104, 0, 32'h0, 1, 0, 32'h0, 32'hCAFE_0104, 0, 1);
    txn(1, 32'h50, 0, 32'h0, 4, 0, 32'h0, 32'hCAFE_0050, 0, 4);
    txn(0, 32'h60, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 4);
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    contend(6);
    mem_lat = 2;
    mem_over = 0;
    bus.d_write_enable = 1'b0;
    bus.d_address = 32'h70;
    bus.d_req = 1'b1;
    for (int k = 0; k < 10 && !bus.m_req; k++) begin
      @(posedge clk);
      #2;
    end
    chk("midop_granted", 32'(bus.m_req), 1);
    @(posedge clk);
    #2;
    chk("midop_mem_valid", 32'(bus.m_data_valid), 1);
    reset = 1'b1;
    bus.d_req = 1'b0;
    #1;
    chk("midop_no_valid", 32'(bus.d_data_valid), 0);
    @(posedge clk);
    #2;
    reset_vals();
    reset = 1'b0;
    contend(2);
    for (int k = 0; k < 2000 && !done0; k++) @(posedge clk);
    chk("t0_finished", 32'(done0), 1);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter. It shares a single unified memory port between the DLX instruction-fetch port (i_*) and data port (d_*). It grants one transaction at a time and uses round-robin when both ports request together. It routes the memory response back to the granted requester and terminates hung transactions with an error after a programmable timeout. It sits between the DLX core and the unified RAM model.

## Interface
- TIMEOUT, 255: max busy cycles without m_data_valid before forced error completion; 0 disables timeout; range 0..65535
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  instruction read request, held until i_data_valid
- i_address  in  32  fetch address, stable while i_req high
- i_data_read  out  32  fetch data, meaningful when i_data_valid
- i_data_valid  out  1  one-cycle completion pulse for instruction port
- i_err  out  1  qualifies i_data_valid: 1 = timeout, data forced 0
- d_req  in  1  data request, held until d_data_valid
- d_write_enable  in  1  1 = write, 0 = read; stable while d_req high
- d_address  in  32  data address
- d_data_write  in  32  write data
- d_data_read  out  32  read data, meaningful when d_data_valid and read
- d_data_valid  out  1  one-cycle completion pulse for data port
- d_err  out  1  qualifies d_data_valid: 1 = timeout
- m_req  out  1  memory request, held until completion
- m_write_enable  out  1  memory write strobe, valid with m_req
- m_address  out  32  memory address
- m_data_write  out  32  memory write data
- m_data_read  in  32  memory read data
- m_data_valid  in  1  memory completion, sampled only while m_req high

## Operation
- States: IDLE, I_BUSY, D_BUSY. Reset → IDLE, last_grant = I, timeout counter = 0.
- IDLE, only i_req → I_BUSY. Only d_req → D_BUSY. Both → grant the port not in last_grant. After reset, D wins the first tie.
- On entry to a busy state: latch the granted port's address, write enable and write data into the m_* output registers. Set last_grant to that port. Clear the counter.
- In a busy state, m_data_valid = 1 completes the transaction:
  - Route m_data_read to the granted port's data output.
  - Pulse that port's valid for that same cycle (combinational from m_data_valid), with err = 0.
  - Next state IDLE.
- In a busy state without m_data_valid, the counter increments. If TIMEOUT ≠ 0 and the counter equals TIMEOUT-1:
  - Forced completion: the granted port's valid = 1, err = 1, data = 0.
  - Next state IDLE. m_req drops next cycle.
- The non-granted port's valid and err stay 0. Its data output is 0 whenever its valid is 0.
- m_data_valid while IDLE is ignored and produces no valid pulse.
- No pipelining: at most one outstanding memory transaction.
- The arbiter never reorders or drops a held request. A request waits until granted.
- Requester contract: it keeps req, address, write enable and write data stable until its valid pulse. Holding req high after valid is a new request.

## Timing
- Reset values:
  - state IDLE; m_req 0, m_write_enable 0, m_address 0, m_data_write 0.
  - all *_data_valid 0, *_err 0, *_data_read 0.
- Request sampled in IDLE at edge N → m_req and m_* registers high/valid from cycle N+1.
- Minimum latency: memory valid in cycle N+1 → requester valid in cycle N+1 (one cycle, request to completion).
- Completion in cycle K → IDLE in K+1, m_req 0 in K+1. A request pending in K+1 is granted at edge K+1, so m_req rises at K+2. One dead cycle between back-to-back transactions.
- Timeout: with no m_data_valid, the forced completion falls in the TIMEOUT-th busy cycle. Example: TIMEOUT = 4, m_req first high in cycle 1 → i/d err pulse in cycle 4.
- m_data_valid in the same cycle as the timeout match: normal completion, err = 0.
- Reset asserted mid-transaction:
  - Next edge forces IDLE and m_req 0.
  - No valid pulse for the aborted transaction, including when m_data_valid arrives in the reset cycle.
  - last_grant returns to I.

## Test plan
- Single fetch: i_req = 1, i_address = 0x100; memory returns 0xDEADBEEF 2 cycles after m_req rises → m_address = 0x100, m_write_enable = 0, one i_data_valid pulse with i_data_read = 0xDEADBEEF and i_err = 0; d_data_valid stays 0.
- Tie after reset: i_req and d_req both rise in the same cycle and stay held → D served first, then I; m_req low for exactly one cycle between the two.
- Continuous contention: both requests held for 6 transactions → grants alternate D, I, D, I, D, I.
- Data write: d_req = 1, d_write_enable = 1, d_address = 0x40, d_data_write = 0x12345678 → m_* carry those values; d_data_valid pulses on m_data_valid.
- Timeout: TIMEOUT = 4, memory never responds to i_req → i_data_valid = 1 with i_err = 1 and i_data_read = 0 in the 4th m_req cycle; m_req = 0 the next cycle. Repeat with TIMEOUT = 0 → no completion after 1000 cycles.
- Reset mid-op: reset asserted while in D_BUSY, with m_data_valid arriving in the same cycle → no d_data_valid pulse; all outputs at reset values on the next cycle; next tie grants D.
